// File: rtl/vga_timing_pkg.sv
// Shared VGA timing presets, sync polarity type and total-period helper.
package vga_timing_pkg;

   typedef enum logic {ACTIVE_LOW = 1'b0, ACTIVE_HIGH = 1'b1} sync_pol_e;

   // 640x480@60, 25.175 MHz nominal pixel rate
   localparam int        VGA640_H_ACTIVE = 640;
   localparam int        VGA640_H_FP     = 16;
   localparam int        VGA640_H_SYNC   = 96;
   localparam int        VGA640_H_BP     = 48;
   localparam int        VGA640_V_ACTIVE = 480;
   localparam int        VGA640_V_FP     = 10;
   localparam int        VGA640_V_SYNC   = 2;
   localparam int        VGA640_V_BP     = 33;
   localparam sync_pol_e VGA640_HS_POL   = ACTIVE_LOW;
   localparam sync_pol_e VGA640_VS_POL   = ACTIVE_LOW;

   // 800x600@60, 40 MHz nominal pixel rate
   localparam int        VGA800_H_ACTIVE = 800;
   localparam int        VGA800_H_FP     = 40;
   localparam int        VGA800_H_SYNC   = 128;
   localparam int        VGA800_H_BP     = 88;
   localparam int        VGA800_V_ACTIVE = 600;
   localparam int        VGA800_V_FP     = 1;
   localparam int        VGA800_V_SYNC   = 4;
   localparam int        VGA800_V_BP     = 23;
   localparam sync_pol_e VGA800_HS_POL   = ACTIVE_HIGH;
   localparam sync_pol_e VGA800_VS_POL   = ACTIVE_HIGH;

   function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Clock-enabled shift register for the valid/hsync/vsync pipeline; DEPTH=0 is a wire.
module vga_sync_delay #(
   parameter int               WIDTH = 1,
   parameter int               DEPTH = 0,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = &{1'b0, clk, rst, ce, flush};
      assign q = d;
   end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

      always_comb begin
         stage_d = stage_q;
         if (flush) begin
            stage_d = {DEPTH{INIT}};
         end else if (ce) begin
            stage_d[0] = d;
            for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) stage_q <= {DEPTH{INIT}};
         else      stage_q <= stage_d;
      end

      assign q = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-enable divider and sync delay line.
// Optional 16-bit frame counter built only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CNT_W    = 10,
   parameter int H_ACTIVE = VGA640_H_ACTIVE,
   parameter int H_FP     = VGA640_H_FP,
   parameter int H_SYNC   = VGA640_H_SYNC,
   parameter int H_BP     = VGA640_H_BP,
   parameter int V_ACTIVE = VGA640_V_ACTIVE,
   parameter int V_FP     = VGA640_V_FP,
   parameter int V_SYNC   = VGA640_V_SYNC,
   parameter int V_BP     = VGA640_V_BP,
   parameter bit HS_POL   = VGA640_HS_POL,
   parameter bit VS_POL   = VGA640_VS_POL,
   parameter int PIX_DIV  = 4,
   parameter int PIPE_DLY = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             pix_ce,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             valid,
   output logic             hsync,
   output logic             vsync,
   output logic             line_start,
   output logic             frame_start,
   output logic             vblank_tick,
   output logic [15:0]      frame_cnt
);

   localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_BEG  = V_ACTIVE + V_FP;
   localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;
   localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_VBLANK = CNT_W'(V_ACTIVE);

   if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_bad_cnt_w
      $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CNT_W bits");
   end
   if (PIX_DIV < 1 || PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_param
      $error("vga_timing_gen: PIX_DIV or PIPE_DLY out of range");
   end

   logic             run_q, run_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic             valid_r_q, valid_r_d, hs_r_q, hs_r_d, vs_r_q, vs_r_d;
   logic             h_wrap;
   logic [2:0]       dly_q;

   // run_q holds the divider at 0 for the first enabled clk, so pix_ce lands PIX_DIV clks after en
   assign pix_ce = run_q && (div_q == DIV_LAST);
   assign h_wrap = (h_cnt_q == H_LAST);

   always_comb begin
      run_d     = en;
      div_d     = '0;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      valid_r_d = valid_r_q;
      hs_r_d    = hs_r_q;
      vs_r_d    = vs_r_q;
      if (!en) begin
         h_cnt_d   = '0;
         v_cnt_d   = '0;
         valid_r_d = 1'b0;
         hs_r_d    = ~HS_POL;
         vs_r_d    = ~VS_POL;
      end else begin
         if (run_q && div_q != DIV_LAST) div_d = div_q + DIV_W'(1);
         if (pix_ce) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
            if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
            valid_r_d = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
            hs_r_d    = (int'(h_cnt_q) >= HS_BEG && int'(h_cnt_q) < HS_END) ? HS_POL : ~HS_POL;
            vs_r_d    = (int'(v_cnt_q) >= VS_BEG && int'(v_cnt_q) < VS_END) ? VS_POL : ~VS_POL;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q     <= 1'b0;
         div_q     <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         valid_r_q <= 1'b0;
         hs_r_q    <= ~HS_POL;
         vs_r_q    <= ~VS_POL;
      end else begin
         run_q     <= run_d;
         div_q     <= div_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         valid_r_q <= valid_r_d;
         hs_r_q    <= hs_r_d;
         vs_r_q    <= vs_r_d;
      end
   end

   vga_sync_delay #(
      .WIDTH (3),
      .DEPTH (PIPE_DLY),
      .INIT  ({1'b0, ~HS_POL, ~VS_POL})
   ) u_sync_delay (
      .clk   (clk),
      .rst   (rst),
      .ce    (pix_ce),
      .flush (!en),
      .d     ({valid_r_q, hs_r_q, vs_r_q}),
      .q     (dly_q)
   );

   assign {valid, hsync, vsync} = dly_q;
   assign h_cnt       = h_cnt_q;
   assign v_cnt       = v_cnt_q;
   assign line_start  = pix_ce && (h_cnt_q == '0);
   assign frame_start = line_start && (v_cnt_q == '0);
   assign vblank_tick = line_start && (v_cnt_q == V_VBLANK);

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) frame_cnt_q <= '0;
      else      frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed checks of vga_timing_gen: defaults, a small delayed-pipeline raster, and inverted polarity.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
      end
   endtask

   // A: default 640x480, PIX_DIV=4, PIPE_DLY=0
   logic        a_rst, a_en, a_ce, a_val, a_hs, a_vs, a_ls, a_fs, a_vt;
   logic [9:0]  a_h, a_v;
   logic [15:0] a_fc;

   vga_timing_gen u_a (
      .clk(clk), .rst(a_rst), .en(a_en), .pix_ce(a_ce), .h_cnt(a_h), .v_cnt(a_v),
      .valid(a_val), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls),
      .frame_start(a_fs), .vblank_tick(a_vt), .frame_cnt(a_fc)
   );

   // B: 16x10 raster (8/2/3/3, 6/1/2/1), PIX_DIV=2, PIPE_DLY=2
   logic        b_rst, b_en, b_ce, b_val, b_hs, b_vs, b_ls, b_fs, b_vt;
   logic [4:0]  b_h, b_v;
   logic [15:0] b_fc;

   vga_timing_gen #(
      .CNT_W(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(2), .PIPE_DLY(2)
   ) u_b (
      .clk(clk), .rst(b_rst), .en(b_en), .pix_ce(b_ce), .h_cnt(b_h), .v_cnt(b_v),
      .valid(b_val), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls),
      .frame_start(b_fs), .vblank_tick(b_vt), .frame_cnt(b_fc)
   );

   // C: 640x480 timing, active-high syncs, PIX_DIV=1
   logic        c_rst, c_en, c_ce, c_val, c_hs, c_vs, c_ls, c_fs, c_vt;
   logic [9:0]  c_h, c_v;
   logic [15:0] c_fc;

   vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(1)) u_c (
      .clk(clk), .rst(c_rst), .en(c_en), .pix_ce(c_ce), .h_cnt(c_h), .v_cnt(c_v),
      .valid(c_val), .hsync(c_hs), .vsync(c_vs), .line_start(c_ls),
      .frame_start(c_fs), .vblank_tick(c_vt), .frame_cnt(c_fc)
   );

   initial begin
      int n, m, k;
      logic [15:0] fc_before;
      a_rst = 1'b0; a_en = 1'b0;
      b_rst = 1'b0; b_en = 1'b0;
      c_rst = 1'b0; c_en = 1'b0;
      repeat (3) @(negedge clk);

      // ---- A: reset state, divider start-up, line period, hsync window
      chk("a_rst_ce", a_ce, 0);
      chk("a_rst_h", a_h, 0);
      chk("a_rst_v", a_v, 0);
      chk("a_rst_valid", a_val, 0);
      chk("a_rst_hs", a_hs, 1);
      chk("a_rst_vs", a_vs, 1);
      chk("a_rst_ls", a_ls, 0);
      chk("a_rst_fc", a_fc, 0);

      a_rst = 1'b1; a_en = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!a_ce && n < 20);
      chk("a_first_ce_clk", n, 4);
      chk("a_first_fs", a_fs, 1);
      chk("a_first_h", a_h, 0);

      n = 0;
      do begin @(negedge clk); n++; end while (!a_ls && n < 4000);
      chk("a_line_period", n, 3200);
      chk("a_line2_v", a_v, 1);

      n = 0;
      do begin @(negedge clk); n++; end while (a_hs && n < 4000);
      chk("a_hs_fall_h", a_h, 657);
      n = 0; m = 0;
      while (!a_hs && n < 1000) begin
         n++;
         if (a_ce) m++;
         @(negedge clk);
      end
      chk("a_hs_clks", n, 384);
      chk("a_hs_pix", m, 96);
      chk("a_hs_rise_h", a_h, 753);

      // asynchronous reset while hsync is asserted
      n = 0;
      do begin @(negedge clk); n++; end while (a_hs && n < 4000);
      #2 a_rst = 1'b0;
      #1;
      chk("a_async_hs", a_hs, 1);
      chk("a_async_h", a_h, 0);
      chk("a_async_v", a_v, 0);
      chk("a_async_ce", a_ce, 0);
      chk("a_async_fc", a_fc, 0);
      a_en = 1'b0;

      // ---- B: frame/vblank spacing and the 3-pixel pipeline latency
      @(negedge clk);
      b_rst = 1'b1; b_en = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!b_fs && n < 50);
      chk("b_first_ce_clk", n, 2);
      n = 0;
      do begin @(negedge clk); n++; end while (!b_vt && n < 1000);
      chk("b_vblank_clks", n, 192);
      chk("b_vblank_v", b_v, 6);
      m = 0;
      do begin @(negedge clk); m++; end while (!b_fs && m < 1000);
      chk("b_frame_clks", n + m, 320);

      n = 0;
      do begin @(negedge clk); n++; end while (!b_val && n < 400);
      chk("b_val_rise_h", b_h, 3);
      chk("b_val_rise_v", b_v, 0);
      n = 0;
      do begin @(negedge clk); n++; end while (b_val && n < 400);
      chk("b_val_fall_h", b_h, 11);
      n = 0;
      do begin @(negedge clk); n++; end while (b_hs && n < 400);
      chk("b_hs_fall_h", b_h, 13);
      m = 0; n = 0;
      while (!b_hs && n < 400) begin
         n++;
         if (b_ce) m++;
         @(negedge clk);
      end
      chk("b_hs_pix", m, 3);
      chk("b_hs_rise_h", b_h, 0);
      chk("b_hs_rise_v", b_v, 1);

      n = 0;
      do begin @(negedge clk); n++; end while (b_vs && n < 400);
      chk("b_vs_fall_v", b_v, 7);
      chk("b_vs_fall_h", b_h, 3);
      n = 0;
      while (!b_vs && n < 400) begin n++; @(negedge clk); end
      chk("b_vs_clks", n, 64);

      // en dropped mid-frame, then restored
      n = 0;
      while (!(b_h == 5'd5 && b_v == 5'd3) && n < 400) begin n++; @(negedge clk); end
      chk("b_drop_pos_found", (n < 400), 1);
      b_en = 1'b0;
      k = 0;
      repeat (50) begin
         @(negedge clk);
         if (b_ce || b_ls || b_fs || b_vt) k++;
      end
      chk("b_off_strobes", k, 0);
      chk("b_off_h", b_h, 0);
      chk("b_off_v", b_v, 0);
      chk("b_off_valid", b_val, 0);
      chk("b_off_hs", b_hs, 1);
      chk("b_off_vs", b_vs, 1);
      fc_before = b_fc;
      b_en = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!b_ce && n < 20);
      chk("b_reen_ce_clk", n, 2);
      chk("b_reen_fs", b_fs, 1);
      chk("b_reen_valid", b_val, 0);
      @(negedge clk);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("b_reen_fc", b_fc, 32'(fc_before) + 1);
`else
      chk("b_reen_fc", b_fc, 0);
`endif
      b_en = 1'b0;

      // ---- C: active-high syncs, pix_ce every clk, 800-clk line
      chk("c_rst_hs", c_hs, 0);
      chk("c_rst_vs", c_vs, 0);
      c_rst = 1'b1; c_en = 1'b1;
      @(negedge clk);
      chk("c_first_ce", c_ce, 1);
      chk("c_first_fs", c_fs, 1);
      n = 0; m = 0; k = 0;
      repeat (800) begin
         if (c_ce) n++;
         if (c_ls) m++;
         if (c_hs) k++;
         @(negedge clk);
      end
      chk("c_ce_count", n, 800);
      chk("c_ls_count", m, 1);
      chk("c_hs_high_clks", k, 96);
      chk("c_line2_ls", c_ls, 1);
      chk("c_line2_v", c_v, 1);
      chk("c_vs_idle", c_vs, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
